// File: rtl/shift_reg_univ_pkg.sv
// Shared operation encodings for the universal shift register and its users.
package shift_reg_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROTL  = 3'd3,
    MODE_ROTR  = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_e;

endpackage

// File: rtl/shift_reg_univ_popcount.sv
// Combinational population count: number of set bits in an N-bit vector.
module popcount #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]             in_i,
  output logic [$clog2(N+1)-1:0]   cnt_o
);

  localparam int unsigned CW = $clog2(N + 1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_o = cnt_o + CW'(in_i[i]);
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: shift, rotate, parallel load/clear with per-stage
// valid bits and an occupancy count that always matches valid_o.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Size  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [2:0]                  mode_i,
  input  logic [Width-1:0]            data_i,
  input  logic [Width*Size-1:0]       load_i,
  output logic [Width-1:0]            head_o,
  output logic [Width-1:0]            tail_o,
  output logic [Width*Size-1:0]       par_o,
  output logic [Size-1:0]             valid_o,
  output logic [$clog2(Size+1)-1:0]   count_o
);

  localparam int unsigned CountW = $clog2(Size + 1);

  logic [Size-1:0][Width-1:0] mem_q, mem_d, load_s;
  logic [Size-1:0]            vld_q, vld_d;
  logic [CountW-1:0]          cnt_q, cnt_d;

  for (genvar k = 0; k < Size; k++) begin : g_slice
    assign load_s[k]                   = load_i[k*Width +: Width];
    assign par_o[k*Width +: Width]     = mem_q[k];
  end

  // Index 0 is the low stage, so "left" moves data toward higher indices.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (en_i) begin
      case (mode_e'(mode_i))
        MODE_SHL: begin
          mem_d = {mem_q[Size-2:0], data_i};
          vld_d = {vld_q[Size-2:0], 1'b1};
        end
        MODE_SHR: begin
          mem_d = {data_i, mem_q[Size-1:1]};
          vld_d = {1'b1, vld_q[Size-1:1]};
        end
        MODE_ROTL: begin
          mem_d = {mem_q[Size-2:0], mem_q[Size-1]};
          vld_d = {vld_q[Size-2:0], vld_q[Size-1]};
        end
        MODE_ROTR: begin
          mem_d = {mem_q[0], mem_q[Size-1:1]};
          vld_d = {vld_q[0], vld_q[Size-1:1]};
        end
        MODE_LOAD: begin
          mem_d = load_s;
          vld_d = '1;
        end
        MODE_CLEAR: begin
          mem_d = '0;
          vld_d = '0;
        end
        default: begin
          mem_d = mem_q;
          vld_d = vld_q;
        end
      endcase
    end
  end

  // Counting the next-state valid bits keeps count_o aligned with valid_o.
  popcount #(.N(Size)) u_popcount (
    .in_i  (vld_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[0];
  assign tail_o  = mem_q[Size-1];
  assign valid_o = vld_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios plus random operations on a
// Size=4/Width=8 instance and a Size=2/Width=1 instance against an array model.
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [2:0]  mode;
  logic [7:0]  data;
  logic [31:0] load;

  logic [7:0]  head_a, tail_a;
  logic [31:0] par_a;
  logic [3:0]  valid_a;
  logic [2:0]  count_a;

  logic        head_b, tail_b;
  logic [1:0]  par_b, valid_b, count_b;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Model state: unit 0 = Size 4 / Width 8, unit 1 = Size 2 / Width 1.
  logic [7:0] mm [2][4];
  bit         vv [2][4];

  always #5 clk = ~clk;

  shift_reg_univ #(.Width(8), .Size(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .data_i(data),
    .load_i(load), .head_o(head_a), .tail_o(tail_a), .par_o(par_a),
    .valid_o(valid_a), .count_o(count_a)
  );

  shift_reg_univ #(.Width(1), .Size(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .data_i(data[0]),
    .load_i(load[1:0]), .head_o(head_b), .tail_o(tail_b), .par_o(par_b),
    .valid_o(valid_b), .count_o(count_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mstep(input int u);
    int         s, w;
    logic [7:0] om [4];
    bit         ov [4];
    logic [7:0] msk, d;
    s   = (u == 0) ? 4 : 2;
    w   = (u == 0) ? 8 : 1;
    msk = (u == 0) ? 8'hFF : 8'h01;
    d   = data & msk;
    for (int k = 0; k < 4; k++) begin
      om[k] = mm[u][k];
      ov[k] = vv[u][k];
    end
    if (rst) begin
      for (int k = 0; k < s; k++) begin mm[u][k] = '0; vv[u][k] = 0; end
    end else if (en) begin
      for (int k = 0; k < s; k++) begin
        case (mode)
          1: begin mm[u][k] = (k == 0) ? d : om[k-1]; vv[u][k] = (k == 0) ? 1'b1 : ov[k-1]; end
          2: begin mm[u][k] = (k == s-1) ? d : om[k+1]; vv[u][k] = (k == s-1) ? 1'b1 : ov[k+1]; end
          3: begin mm[u][k] = om[(k+s-1)%s]; vv[u][k] = ov[(k+s-1)%s]; end
          4: begin mm[u][k] = om[(k+1)%s]; vv[u][k] = ov[(k+1)%s]; end
          5: begin mm[u][k] = (load >> (k*w)) & msk; vv[u][k] = 1; end
          6: begin mm[u][k] = '0; vv[u][k] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] pa, pb;
    logic [3:0]  va;
    logic [1:0]  vb;
    int          ca, cb;
    pa = '0; pb = '0; va = '0; vb = '0; ca = 0; cb = 0;
    for (int k = 0; k < 4; k++) begin
      pa = pa | (32'(mm[0][k]) << (k*8));
      va[k] = vv[0][k];
      ca += vv[0][k];
    end
    for (int k = 0; k < 2; k++) begin
      pb = pb | (32'(mm[1][k] & 8'h01) << k);
      vb[k] = vv[1][k];
      cb += vv[1][k];
    end
    check("a_head",  64'(head_a),  64'(mm[0][0]));
    check("a_tail",  64'(tail_a),  64'(mm[0][3]));
    check("a_par",   64'(par_a),   64'(pa));
    check("a_valid", 64'(valid_a), 64'(va));
    check("a_count", 64'(count_a), 64'(ca));
    check("b_head",  64'(head_b),  64'(mm[1][0] & 8'h01));
    check("b_tail",  64'(tail_b),  64'(mm[1][1] & 8'h01));
    check("b_par",   64'(par_b),   64'(pb[1:0]));
    check("b_valid", 64'(valid_b), 64'(vb));
    check("b_count", 64'(count_b), 64'(cb));
  endtask

  task automatic step(input bit r, input bit e, input logic [2:0] m,
                      input logic [7:0] d, input logic [31:0] ld);
    rst = r; en = e; mode = m; data = d; load = ld;
    @(posedge clk);
    #1;
    mstep(0);
    mstep(1);
    compare_all();
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 4; k++) begin mm[u][k] = 'x; vv[u][k] = 0; end
    step(1, 0, MODE_HOLD, 8'h00, 32'h0);
    check("rst_par", 64'(par_a), 64'h0);
    check("rst_cnt", 64'(count_a), 64'h0);

    step(0, 1, MODE_SHL, 8'h11, 32'h0);
    step(0, 1, MODE_SHL, 8'h22, 32'h0);
    step(0, 1, MODE_SHL, 8'h33, 32'h0);
    check("fill_tail_early", 64'(tail_a), 64'h0);
    step(0, 1, MODE_SHL, 8'h44, 32'h0);
    check("fill_tail",  64'(tail_a),  64'h11);
    check("fill_valid", 64'(valid_a), 64'hF);
    check("fill_count", 64'(count_a), 64'd4);
    check("fill_par",   64'(par_a),   64'h11223344);

    step(0, 1, MODE_SHL, 8'h55, 32'h0);
    check("full_shl_tail",  64'(tail_a),  64'h22);
    check("full_shl_head",  64'(head_a),  64'h55);
    check("full_shl_count", 64'(count_a), 64'd4);
    step(0, 1, MODE_SHR, 8'h66, 32'h0);
    check("full_shr_head",  64'(head_a),  64'h44);
    check("full_shr_tail",  64'(tail_a),  64'h66);
    check("full_shr_count", 64'(count_a), 64'd4);

    step(1, 1, MODE_HOLD, 8'h00, 32'h0);
    step(0, 1, MODE_SHL, 8'hA5, 32'h0);
    check("one_valid", 64'(valid_a), 64'b0001);
    check("one_count", 64'(count_a), 64'd1);
    repeat (3) step(0, 1, MODE_ROTL, 8'hFF, 32'h0);
    check("rotl_valid", 64'(valid_a), 64'b1000);
    check("rotl_tail",  64'(tail_a),  64'hA5);
    check("rotl_count", 64'(count_a), 64'd1);
    check("b_rotl_valid", 64'(valid_b), 64'b10);
    step(0, 1, MODE_ROTR, 8'hFF, 32'h0);
    check("rotr_valid", 64'(valid_a), 64'b0100);
    check("b_rotr_valid", 64'(valid_b), 64'b01);

    step(0, 1, MODE_LOAD, 8'h00, 32'hDEADBEEF);
    check("load_head",  64'(head_a),  64'hEF);
    check("load_tail",  64'(tail_a),  64'hDE);
    check("load_count", 64'(count_a), 64'd4);
    repeat (3) step(0, 0, MODE_SHL, 8'h77, 32'h0);
    check("hold_par", 64'(par_a), 64'hDEADBEEF);
    step(0, 1, MODE_RSVD, 8'h77, 32'h12345678);
    check("rsvd_par", 64'(par_a), 64'hDEADBEEF);
    step(0, 1, MODE_CLEAR, 8'h77, 32'h0);
    check("clr_par",   64'(par_a),   64'h0);
    check("clr_valid", 64'(valid_a), 64'h0);

    step(1, 1, MODE_LOAD, 8'h00, 32'hCAFEF00D);
    check("rstpri_par", 64'(par_a), 64'h0);
    step(0, 1, MODE_LOAD, 8'h00, 32'hCAFEF00D);
    check("postrst_par", 64'(par_a), 64'hCAFEF00D);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(31) == 0, $urandom_range(7) != 0, 3'($urandom_range(7)),
           8'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
